// File: rtl/mode_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mode_disp_pkg
// Description : Shared constants and types for the multiplexed mode display.
//               Mode encodings (SW[9:8]), digit slot indices and the blank
//               segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
package mode_disp_pkg;

  // Arithmetic mode selected by SW[9:8]
  localparam logic [1:0] MODE_DIV   = 2'd0;  // floor(2*A/5)
  localparam logic [1:0] MODE_ZEROS = 2'd1;  // number of zero bits in B
  localparam logic [1:0] MODE_LOGIC = 2'd2;  // single-bit logic expression on A
  localparam logic [1:0] MODE_PASS  = 2'd3;  // A unchanged

  // Scan index of each displayed field; indices 4 and up are blank
  localparam logic [2:0] SLOT_RES  = 3'd0;
  localparam logic [2:0] SLOT_A    = 3'd1;
  localparam logic [2:0] SLOT_B    = 3'd2;
  localparam logic [2:0] SLOT_MODE = 3'd3;

  // Active-low segment pattern with every segment dark
  localparam logic [6:0] HEX_BLANK = 7'h7F;

  // Field layout of the switch bank
  typedef struct packed {
    logic [1:0] mode;
    logic [3:0] b;
    logic [3:0] a;
  } sw_fields_t;

endpackage
`default_nettype wire

// File: rtl/mode_scan_display_dec.sv
`default_nettype none
// ============================================================================
// Module      : mode_scan_display_dec
// Description : Hex nibble to seven-segment decoder, active-low outputs.
//               Ports: x[3:0] nibble in; y[6:0] segments {g,f,e,d,c,b,a},
//               0 = segment lit.
// Revision    : 1.0 - initial release
// ============================================================================
module mode_scan_display_dec (
  input  logic [3:0] x,
  output logic [6:0] y
);

  always_comb begin
    y = 7'h7F;
    case (x)
      4'h0: y = 7'h40;
      4'h1: y = 7'h79;
      4'h2: y = 7'h24;
      4'h3: y = 7'h30;
      4'h4: y = 7'h19;
      4'h5: y = 7'h12;
      4'h6: y = 7'h02;
      4'h7: y = 7'h78;
      4'h8: y = 7'h00;
      4'h9: y = 7'h10;
      4'hA: y = 7'h08;
      4'hB: y = 7'h03;
      4'hC: y = 7'h46;
      4'hD: y = 7'h21;
      4'hE: y = 7'h06;
      4'hF: y = 7'h0E;
      default: y = 7'h7F;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mode_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : mode_scan_display
// Description : Registers one of four switch-selected arithmetic results and
//               time-multiplexes it, both input nibbles and the mode across
//               N_DIGITS seven-segment digits.
//               Ports: CLK100MHZ clock; CPU_RESETN async active-low reset;
//               SW[9:0] {mode, B, A}; HOLD freezes the result;
//               AN[N_DIGITS-1:0] one-hot anodes; HEX[6:0] segments
//               (active-low); DP decimal point (active-low).
// Revision    : 1.0 - initial release
// ============================================================================
module mode_scan_display
  import mode_disp_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int AN_ACT_LOW  = 0
) (
  input  logic                CLK100MHZ,
  input  logic                CPU_RESETN,
  input  logic [9:0]          SW,
  input  logic                HOLD,
  output logic [N_DIGITS-1:0] AN,
  output logic [6:0]          HEX,
  output logic                DP
);

  localparam int               CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [2:0]       IDX_MAX = 3'(N_DIGITS - 1);

  // Synchronisers
  logic [9:0] sw_s1_q, sw_s2_q;
  logic       hold_s1_q, hold_s2_q;

  // Result, scan state and registered outputs. Outputs are held in
  // active-high form so that the all-zero reset state means "dark".
  logic [3:0]          res_q,  res_d;
  logic [CNT_W-1:0]    cnt_q,  cnt_d;
  logic [2:0]          idx_q,  idx_d;
  logic [N_DIGITS-1:0] an_q,   an_d;
  logic [6:0]          seg_q,  seg_d;
  logic                dp_q,   dp_d;

  sw_fields_t sw_f;
  logic [3:0] res_calc;
  logic [3:0] zeros_cnt;
  logic [3:0] nib;
  logic [6:0] dec_y;
  logic       primed;
  logic       load;

  assign sw_f = sw_s2_q;

  // Result computation on the synchronised switches
  always_comb begin
    zeros_cnt = 4'd4 - (4'(sw_f.b[0]) + 4'(sw_f.b[1]) + 4'(sw_f.b[2]) + 4'(sw_f.b[3]));
    res_calc  = sw_f.a;
    case (sw_f.mode)
      MODE_DIV:   res_calc = 4'(({1'b0, sw_f.a} << 1) / 5'd5);
      MODE_ZEROS: res_calc = zeros_cnt;
      MODE_LOGIC: res_calc = {3'b000, (~sw_f.a[0] & ~sw_f.a[1]) ^ (sw_f.a[2] | sw_f.a[3])};
      MODE_PASS:  res_calc = sw_f.a;
      default:    res_calc = sw_f.a;
    endcase
    res_d = hold_s2_q ? res_q : res_calc;
  end

  // Refresh counter and scan index. Right after reset no anode is lit yet;
  // the first edge lights digit 0 without advancing the counter so that the
  // first slot lasts a full REFRESH_DIV cycles like every other slot.
  always_comb begin
    primed = |an_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    load   = 1'b0;
    if (!primed) begin
      load = 1'b1;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
      load  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Nibble for the slot about to be shown
  always_comb begin
    nib = 4'h0;
    case (idx_d)
      SLOT_RES:  nib = res_q;
      SLOT_A:    nib = sw_f.a;
      SLOT_B:    nib = sw_f.b;
      SLOT_MODE: nib = {2'b00, sw_f.mode};
      default:   nib = 4'h0;
    endcase
  end

  mode_scan_display_dec u_dec (
    .x (nib),
    .y (dec_y)
  );

  // Outputs only change at slot boundaries, so a value change inside a slot
  // never produces a partial digit.
  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    if (load) begin
      an_d  = N_DIGITS'(1) << idx_d;
      seg_d = (idx_d > SLOT_MODE) ? ~HEX_BLANK : ~dec_y;
      dp_d  = (idx_d == SLOT_MODE);
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      hold_s1_q <= 1'b0;
      hold_s2_q <= 1'b0;
      res_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      an_q      <= '0;
      seg_q     <= '0;
      dp_q      <= 1'b0;
    end else begin
      sw_s1_q   <= SW;
      sw_s2_q   <= sw_s1_q;
      hold_s1_q <= HOLD;
      hold_s2_q <= hold_s1_q;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  generate
    if (AN_ACT_LOW != 0) begin : g_an_low
      assign AN = ~an_q;
    end else begin : g_an_high
      assign AN = an_q;
    end
  endgenerate

  assign HEX = ~seg_q;
  assign DP  = ~dp_q;

endmodule
`default_nettype wire
